adc_channel_sched: RTL and testbench

ADC_CHANNEL_SCHED -- requirements
Module: adc_channel_sched

---
 rtl/adc_channel_sched_if.sv | 22 ++
 rtl/adc_channel_sched.sv | 182 ++++++++++++++++++
 tb/tb_adc_channel_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_channel_sched_if.sv
// ADC front-end handshake: the scheduler drives the request and channel.
// The front end answers with a one-cycle done pulse that carries the data.
interface adc_channel_sched_if;
  logic        conv_req;
  logic [2:0]  conv_chan;
  logic        conv_done;
  logic [11:0] conv_data;

  modport master (
    output conv_req,
    output conv_chan,
    input  conv_done,
    input  conv_data
  );

  modport slave (
    input  conv_req,
    input  conv_chan,
    output conv_done,
    output conv_data
  );
endinterface

// File: rtl/adc_channel_sched.sv
// Periodic three-channel line-sensor sampler.
// Each frame converts left, centre and right in turn and commits all three at once.
module adc_channel_sched #(
  parameter int          FRAME_PERIOD   = 1000,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [2:0]  LEFT_CH        = 3'd3,
  parameter logic [2:0]  CENTER_CH      = 3'd4,
  parameter logic [2:0]  RIGHT_CH       = 3'd5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        err_clr,
  adc_channel_sched_if.master         adc,
  output logic [11:0]                 left_sensor,
  output logic [11:0]                 center_sensor,
  output logic [11:0]                 right_sensor,
  output logic                        frame_valid,
  output logic                        timeout_err,
  output logic                        overrun_err
);

  localparam int TW = 15;
  localparam int WW = 8;
  localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_PERIOD - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q;
  logic [WW-1:0] wait_q, wait_d;
  logic          conv_req_q, conv_req_d;
  logic [2:0]    conv_chan_q, conv_chan_d;
  logic [11:0]   left_q, center_q, right_q;
  logic          frame_valid_q;
  logic          timeout_err_q;
  logic          overrun_err_q;

  logic frame_tick;
  logic capture;
  logic timeout_evt;
  logic overrun_evt;
  logic commit;

  function automatic logic [2:0] chan_of(input logic [1:0] i);
    case (i)
      2'd0:    return LEFT_CH;
      2'd1:    return CENTER_CH;
      default: return RIGHT_CH;
    endcase
  endfunction

  // Timer free-runs only while enabled; disabling parks it at zero.
  assign frame_tick = enable && (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else if (!enable || frame_tick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    capture     = 1'b0;
    timeout_evt = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_REQ;
          idx_d   = 2'd0;
          wait_d  = '0;
        end
      end
      S_REQ: begin
        // A done on the last allowed cycle still counts as a good conversion.
        if (adc.conv_done || wait_q == WAIT_LAST) begin
          capture     = adc.conv_done;
          timeout_evt = !adc.conv_done;
          wait_d      = '0;
          state_d     = (idx_q == 2'd2) ? S_COMMIT : S_GAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_REQ;
        idx_d   = idx_q + 2'd1;
        wait_d  = '0;
      end
      default: begin
        commit  = 1'b1;
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  assign overrun_evt = frame_tick && (state_q != S_IDLE);
  assign conv_req_d  = (state_d == S_REQ);
  assign conv_chan_d = chan_of(idx_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      wait_q      <= '0;
      conv_req_q  <= 1'b0;
      conv_chan_q <= LEFT_CH;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      conv_req_q  <= conv_req_d;
      conv_chan_q <= conv_chan_d;
    end
  end

  // One shadow register per channel so a timed-out channel keeps its last good sample.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [11:0] shadow_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_q <= '0;
        end else if (capture && idx_q == 2'(gi)) begin
          shadow_q <= adc.conv_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      left_q        <= '0;
      center_q      <= '0;
      right_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= commit;
      if (commit) begin
        left_q   <= g_ch[0].shadow_q;
        center_q <= g_ch[1].shadow_q;
        right_q  <= g_ch[2].shadow_q;
      end
    end
  end

  // Sticky flags: a new error in the same cycle as a clear must not be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (timeout_evt)  timeout_err_q <= 1'b1;
      else if (err_clr) timeout_err_q <= 1'b0;
      if (overrun_evt)  overrun_err_q <= 1'b1;
      else if (err_clr) overrun_err_q <= 1'b0;
    end
  end

  assign adc.conv_req  = conv_req_q;
  assign adc.conv_chan = conv_chan_q;
  assign left_sensor   = left_q;
  assign center_sensor = center_q;
  assign right_sensor  = right_q;
  assign frame_valid   = frame_valid_q;
  assign timeout_err   = timeout_err_q;
  assign overrun_err   = overrun_err_q;

endmodule

// File: tb/tb_adc_channel_sched.sv
// Bench: a frame-level model of the sampler drives a scripted front end (main DUT)
// and a fixed-latency front end on a short-period instance that must overrun.
module tb_adc_channel_sched;

  localparam int FP   = 100;
  localparam int TO   = 8;
  localparam int FP_B = 16;
  localparam int D_B  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, err_clr;
  logic [11:0] left_sensor, center_sensor, right_sensor;
  logic        frame_valid, timeout_err, overrun_err;

  logic        rst_b, enable_b, err_clr_b;
  logic [11:0] left_b, center_b, right_b;
  logic        frame_valid_b, timeout_err_b, overrun_err_b;

  adc_channel_sched_if adc_a();
  adc_channel_sched_if adc_b();

  adc_channel_sched #(.FRAME_PERIOD(FP), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr), .adc(adc_a.master),
    .left_sensor(left_sensor), .center_sensor(center_sensor), .right_sensor(right_sensor),
    .frame_valid(frame_valid), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  adc_channel_sched #(.FRAME_PERIOD(FP_B), .TIMEOUT_CYCLES(64)) u_ovr (
    .clk(clk), .rst(rst_b), .enable(enable_b), .err_clr(err_clr_b), .adc(adc_b.master),
    .left_sensor(left_b), .center_sensor(center_b), .right_sensor(right_b),
    .frame_valid(frame_valid_b), .timeout_err(timeout_err_b), .overrun_err(overrun_err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_tick  = 0;
  int n_frame = 0;
  bit done_b  = 1'b0;

  logic [11:0] m_shadow [3];
  bit          m_terr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] chan_map(input int k);
    return (k == 0) ? 3'd3 : (k == 1) ? 3'd4 : 3'd5;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // d: cycles conv_req is high up to and including the done cycle (0 = never answers).
  task automatic run_frame(input int d0, input int d1, input int d2, input bit fixed_data,
                           input bit clr_tick, input bit clr_at_to, input bit drop_en,
                           input bit rst_at);
    int d [3];
    logic [11:0] data [3];
    int dwell, total, lat;
    bit saw;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int k = 0; k < 3; k++)
      data[k] = fixed_data ? 12'((k + 1) * 12'h111) : 12'($urandom_range(0, 4094));

    while (cyc < t_tick) step();
    check("idle_before_tick", adc_a.conv_req, 0);
    if (clr_tick) begin
      err_clr = 1'b1;
      m_terr  = 1'b0;
    end
    step();
    err_clr = 1'b0;
    total = 0;
    for (int k = 0; k < 3; k++) begin
      dwell = (d[k] >= 1 && d[k] <= TO) ? d[k] : TO;
      total += dwell;
      for (int i = 1; i <= dwell; i++) begin
        check("req_high", adc_a.conv_req, 1);
        check("chan", adc_a.conv_chan, chan_map(k));
        if (rst_at && k == 0 && i == 2) begin
          rst = 1'b1;
          step();
          rst = 1'b0;
          check("rst_req", adc_a.conv_req, 0);
          check("rst_chan", adc_a.conv_chan, 3);
          check("rst_left", left_sensor, 0);
          check("rst_center", center_sensor, 0);
          check("rst_right", right_sensor, 0);
          check("rst_fv", frame_valid, 0);
          check("rst_terr", timeout_err, 0);
          check("rst_oerr", overrun_err, 0);
          for (int j = 0; j < 3; j++) m_shadow[j] = '0;
          m_terr = 1'b0;
          t_tick = cyc + FP - 1;
          adc_a.conv_done = 1'b1;
          adc_a.conv_data = 12'hABC;
          step();
          adc_a.conv_done = 1'b0;
          check("late_done_ignored", adc_a.conv_req, 0);
          $display("[TB] frame %0d aborted by reset", n_frame);
          n_frame++;
          return;
        end
        if (drop_en && k == 1 && i == 1) enable = 1'b0;
        if (i == d[k]) begin
          adc_a.conv_done = 1'b1;
          adc_a.conv_data = data[k];
        end
        if (i == dwell && d[k] != dwell) begin
          m_terr = 1'b1;
          if (clr_at_to) err_clr = 1'b1;
        end
        step();
        adc_a.conv_done = 1'b0;
        err_clr = 1'b0;
      end
      if (d[k] == dwell) m_shadow[k] = data[k];
      check("req_low_after_exit", adc_a.conv_req, 0);
      if (k < 2) begin
        // A stray done in the gap must not be captured.
        adc_a.conv_done = 1'b1;
        adc_a.conv_data = 12'hFFF;
        step();
        adc_a.conv_done = 1'b0;
      end
    end

    lat = -1;
    for (int w = 0; w < 40; w++) begin
      if (frame_valid) begin
        lat = cyc - t_tick;
        break;
      end
      step();
    end
    check("latency", lat, total + 4);
    check("left", left_sensor, m_shadow[0]);
    check("center", center_sensor, m_shadow[1]);
    check("right", right_sensor, m_shadow[2]);
    check("timeout_err", timeout_err, m_terr);
    check("overrun_err", overrun_err, 0);
    $display("[TB] frame %0d d=%0d/%0d/%0d latency=%0d sensors=%03h/%03h/%03h terr=%0d",
             n_frame, d0, d1, d2, lat, left_sensor, center_sensor, right_sensor, timeout_err);
    n_frame++;
    step();
    check("fv_one_cycle", frame_valid, 0);

    if (drop_en) begin
      saw = 1'b0;
      for (int w = 0; w < 150; w++) begin
        if (adc_a.conv_req) saw = 1'b1;
        step();
      end
      check("no_req_when_disabled", saw, 0);
      check("timer_parked", u_dut.timer_q, 0);
      enable = 1'b1;
      t_tick = cyc + FP - 1;
    end else begin
      t_tick += FP;
    end
  endtask

  initial begin : main_seq
    rst = 1'b1; enable = 1'b0; err_clr = 1'b0;
    adc_a.conv_done = 1'b0; adc_a.conv_data = '0;
    for (int j = 0; j < 3; j++) m_shadow[j] = '0;
    m_terr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_req", adc_a.conv_req, 0);
    check("reset_chan", adc_a.conv_chan, 3);
    check("reset_left", left_sensor, 0);
    check("reset_center", center_sensor, 0);
    check("reset_right", right_sensor, 0);
    check("reset_fv", frame_valid, 0);
    check("reset_terr", timeout_err, 0);
    check("reset_oerr", overrun_err, 0);
    enable = 1'b1;
    t_tick = cyc + FP - 1;

    run_frame(5, 5, 5, 1, 0, 0, 0, 0);   // nominal
    run_frame(5, 0, 5, 0, 0, 0, 0, 0);   // centre never answers
    run_frame(3, 8, 2, 0, 1, 0, 0, 0);   // done on the timeout cycle
    run_frame(0, 4, 4, 0, 0, 1, 0, 0);   // clear collides with timeout
    run_frame(5, 5, 5, 0, 1, 0, 0, 1);   // reset mid-request
    run_frame(5, 5, 5, 1, 0, 0, 0, 0);
    for (int f = 0; f < 10; f++)
      run_frame($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10), 0,
                bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)), 0, 0);
    run_frame(4, 6, 3, 0, 0, 0, 1, 0);   // enable drops during centre
    run_frame(2, 7, 9, 0, 1, 0, 0, 0);

    for (int w = 0; w < 1000 && !done_b; w++) step();
    check("overrun_bench_done", done_b, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : ovr_seq
    int cnt, idx, ncap, frames;
    logic [11:0] exp_b [3];
    rst_b = 1'b1; enable_b = 1'b0; err_clr_b = 1'b0;
    adc_b.conv_done = 1'b0; adc_b.conv_data = '0;
    for (int j = 0; j < 3; j++) exp_b[j] = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    enable_b = 1'b1;
    cnt = 0; idx = 0; ncap = 0; frames = 0;
    for (int c = 0; c < 400 && frames < 4; c++) begin
      @(negedge clk);
      adc_b.conv_done = 1'b0;
      if (frame_valid_b) begin
        check("ovr_captures", ncap, 3);
        check("ovr_left", left_b, exp_b[0]);
        check("ovr_center", center_b, exp_b[1]);
        check("ovr_right", right_b, exp_b[2]);
        $display("[TB] overrun-unit frame %0d sensors=%03h/%03h/%03h oerr=%0d",
                 frames, left_b, center_b, right_b, overrun_err_b);
        frames++;
        ncap = 0;
      end
      if (adc_b.conv_req) begin
        if (cnt == 0) check("ovr_chan", adc_b.conv_chan, chan_map(idx));
        cnt++;
        if (cnt == D_B) begin
          adc_b.conv_done = 1'b1;
          adc_b.conv_data = 12'($urandom_range(0, 4095));
          exp_b[idx] = adc_b.conv_data;
          idx = (idx + 1) % 3;
          ncap++;
        end
      end else begin
        cnt = 0;
      end
    end
    check("ovr_frames", frames, 4);
    check("ovr_flag", overrun_err_b, 1);
    check("ovr_no_timeout", timeout_err_b, 0);
    done_b = 1'b1;
  end

endmodule
